// File: rtl/buffer_ring_ctrl.sv
// buffer_ring_ctrl: ring-pointer and occupancy controller for an external Buffer.
// The producer writes PAR_WRITE-word bursts. The consumer sees a PAR_READ-word
// sliding window that advances POP_STRIDE words per pop. Wrap is modulo DEPTH,
// and DEPTH does not have to be a power of two.
// Optional feature macro: BUF_RING_ERR_EN enables the sticky protocol error flag
// 'err'. With the macro undefined, err is tied low.
module buffer_ring_ctrl #(
    parameter int DEPTH      = 4,
    parameter int PAR_WRITE  = 1,
    parameter int PAR_READ   = 1,
    parameter int POP_STRIDE = 1,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic                  buf_wen,
    output logic [ADDR_WIDTH-1:0] buf_waddr,
    output logic [ADDR_WIDTH-1:0] buf_raddr,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  full,
    output logic                  empty,
    output logic                  err
);

    // Handshake: a write fires when wr_valid & wr_ready; a pop fires when
    // rd_ready & rd_valid. Both readies are derived only from the registered
    // count, so a pop never makes room for a write in the same cycle.

    generate
        if (PAR_WRITE < 1 || PAR_WRITE > DEPTH) begin : g_bad_par_write
            $error("buffer_ring_ctrl: PAR_WRITE must be in 1..DEPTH");
        end
        if (PAR_READ < 1 || PAR_READ > DEPTH) begin : g_bad_par_read
            $error("buffer_ring_ctrl: PAR_READ must be in 1..DEPTH");
        end
        if (POP_STRIDE < 1 || POP_STRIDE > PAR_READ) begin : g_bad_stride
            $error("buffer_ring_ctrl: POP_STRIDE must be in 1..PAR_READ");
        end
    endgenerate

    localparam logic [ADDR_WIDTH:0]  DEPTH_P = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]  WSTEP_P = (ADDR_WIDTH + 1)'(PAR_WRITE);
    localparam logic [ADDR_WIDTH:0]  RSTEP_P = (ADDR_WIDTH + 1)'(POP_STRIDE);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] PW_C    = CNT_WIDTH'(PAR_WRITE);
    localparam logic [CNT_WIDTH-1:0] PR_C    = CNT_WIDTH'(PAR_READ);
    localparam logic [CNT_WIDTH-1:0] PS_C    = CNT_WIDTH'(POP_STRIDE);

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  wfire, rfire;

    // The step never exceeds DEPTH, so a single conditional subtract wraps
    // correctly for any DEPTH.
    function automatic logic [ADDR_WIDTH-1:0] ptr_add(input logic [ADDR_WIDTH-1:0] p,
                                                      input logic [ADDR_WIDTH:0]   step);
        logic [ADDR_WIDTH:0] s;
        s = {1'b0, p} + step;
        if (s >= DEPTH_P) begin
            s = s - DEPTH_P;
        end
        return s[ADDR_WIDTH-1:0];
    endfunction

    assign wr_ready  = (DEPTH_C - count_q) >= PW_C;
    assign rd_valid  = count_q >= PR_C;
    assign wfire     = wr_valid & wr_ready;
    assign rfire     = rd_ready & rd_valid;
    assign buf_wen   = wfire;
    assign buf_waddr = wptr_q;
    assign buf_raddr = rptr_q;
    assign count     = count_q;
    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);

    // Next pointer and occupancy from this cycle's write and pop fires.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wfire) begin
            wptr_d  = ptr_add(wptr_q, WSTEP_P);
            count_d = count_d + PW_C;
        end
        if (rfire) begin
            rptr_d  = ptr_add(rptr_q, RSTEP_P);
            count_d = count_d - PS_C;
        end
    end

    // State registers. rst and clear flush the pointers and discard any fire
    // in the same cycle. Buffer contents are left untouched.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

`ifdef BUF_RING_ERR_EN
    logic err_q;

    // Sticky flag: set on an overflow or underflow attempt, cleared only by rst or clear.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            err_q <= 1'b0;
        end else if ((wr_valid && !wr_ready) || (rd_ready && !rd_valid)) begin
            err_q <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    // Simulation-only trace of each protocol error event.
    always @(posedge clk) begin
        if (!rst && !clear) begin
            if (wr_valid && !wr_ready) $display("%0t buffer_ring_ctrl: overflow attempt", $time);
            if (rd_ready && !rd_valid) $display("%0t buffer_ring_ctrl: underflow attempt", $time);
        end
    end
`endif

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_buffer_ring_ctrl.sv
// Bench for buffer_ring_ctrl. The main instance uses DEPTH=6, PAR_WRITE=2,
// PAR_READ=3 and POP_STRIDE=1. A second instance with DEPTH=8 covers the
// power-of-two case. The bench models the attached Buffer memory itself.
module tb_buffer_ring_ctrl;

`ifdef BUF_RING_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clear, wr_valid, rd_ready;
  logic wr_ready, rd_valid, buf_wen, full, empty, err;
  logic [2:0] buf_waddr, buf_raddr, count;
  logic [15:0] din;

  logic clear8, wr_valid8, rd_ready8;
  logic wr_ready8, rd_valid8, buf_wen8, full8, empty8, err8;
  logic [2:0] buf_waddr8, buf_raddr8;
  logic [3:0] count8;

  buffer_ring_ctrl #(.DEPTH(6), .PAR_WRITE(2), .PAR_READ(3), .POP_STRIDE(1)) dut (
    .clk(clk), .rst(rst), .clear(clear), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .buf_wen(buf_wen), .buf_waddr(buf_waddr),
    .buf_raddr(buf_raddr), .count(count), .full(full), .empty(empty), .err(err)
  );

  buffer_ring_ctrl #(.DEPTH(8), .PAR_WRITE(1), .PAR_READ(1), .POP_STRIDE(1)) dut8 (
    .clk(clk), .rst(rst), .clear(clear8), .wr_valid(wr_valid8), .wr_ready(wr_ready8),
    .rd_ready(rd_ready8), .rd_valid(rd_valid8), .buf_wen(buf_wen8), .buf_waddr(buf_waddr8),
    .buf_raddr(buf_raddr8), .count(count8), .full(full8), .empty(empty8), .err(err8)
  );

  // Attached Buffer: writes two words at the clock edge, reads are combinational.
  logic [7:0] mem [6];
  always @(posedge clk) begin
    if (buf_wen) begin
      mem[buf_waddr] <= din[7:0];
      mem[(buf_waddr == 3'd5) ? 3'd0 : buf_waddr + 3'd1] <= din[15:8];
    end
  end

  function automatic logic [23:0] dout_win();
    int r;
    r = int'(buf_raddr);
    return {mem[(r + 2) % 6], mem[(r + 1) % 6], mem[r % 6]};
  endfunction

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        clr, wv, rr;
    logic [15:0] din;
    int          c, wa, ra;
    logic        wrdy, rv, wen;
    logic [23:0] dout;
    logic        er;
  } vec_t;

  function automatic vec_t mk(logic clr, logic wv, logic rr, logic [15:0] d, int c, int wa,
                              int ra, logic wrdy, logic rv, logic wen, logic [23:0] dout,
                              logic er);
    vec_t v;
    v.clr = clr; v.wv = wv; v.rr = rr; v.din = d; v.c = c; v.wa = wa; v.ra = ra;
    v.wrdy = wrdy; v.rv = rv; v.wen = wen; v.dout = dout; v.er = er;
    return v;
  endfunction

  vec_t tbl [19];

  // ---------------- higher-level model for random phase ----------------
  logic [7:0] word_q [$];
  int wr_words, rd_words;
  bit err_m;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e;
    e = ERR_ON;
    // Fill, blocked write, window slide, underflow, wrap, simultaneous, clear.
    tbl[0]  = mk(0, 1, 0, 16'h0100, 0, 0, 0, 1, 0, 1, 24'h0, 0);
    tbl[1]  = mk(0, 1, 0, 16'h0302, 2, 2, 0, 1, 0, 1, 24'h0, 0);
    tbl[2]  = mk(0, 1, 0, 16'h0504, 4, 4, 0, 1, 1, 1, 24'h020100, 0);
    tbl[3]  = mk(0, 1, 0, 16'hEEEE, 6, 0, 0, 0, 1, 0, 24'h020100, 0);
    tbl[4]  = mk(0, 0, 1, 16'h0000, 6, 0, 0, 0, 1, 0, 24'h020100, e);
    tbl[5]  = mk(0, 0, 1, 16'h0000, 5, 0, 1, 0, 1, 0, 24'h030201, e);
    tbl[6]  = mk(0, 0, 1, 16'h0000, 4, 0, 2, 1, 1, 0, 24'h040302, e);
    tbl[7]  = mk(0, 0, 1, 16'h0000, 3, 0, 3, 1, 1, 0, 24'h050403, e);
    tbl[8]  = mk(0, 0, 1, 16'h0000, 2, 0, 4, 1, 0, 0, 24'h0, e);
    tbl[9]  = mk(0, 1, 0, 16'h0706, 2, 0, 4, 1, 0, 1, 24'h0, e);
    tbl[10] = mk(0, 0, 1, 16'h0000, 4, 2, 4, 1, 1, 0, 24'h060504, e);
    tbl[11] = mk(0, 1, 1, 16'h0908, 3, 2, 5, 1, 1, 1, 24'h070605, e);
    tbl[12] = mk(0, 1, 1, 16'h0B0A, 4, 4, 0, 1, 1, 1, 24'h080706, e);
    tbl[13] = mk(0, 0, 1, 16'h0000, 5, 0, 1, 0, 1, 0, 24'h090807, e);
    tbl[14] = mk(0, 1, 0, 16'h0D0C, 4, 0, 2, 1, 1, 1, 24'h0A0908, e);
    tbl[15] = mk(0, 1, 1, 16'hEEEE, 6, 2, 2, 0, 1, 0, 24'h0A0908, e);
    tbl[16] = mk(0, 0, 0, 16'h0000, 5, 2, 3, 0, 1, 0, 24'h0B0A09, e);
    tbl[17] = mk(1, 0, 1, 16'h0000, 5, 2, 3, 0, 1, 0, 24'h0B0A09, e);
    tbl[18] = mk(0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 24'h0, 0);

    // Reset: rst held for two cycles.
    rst = 1'b1; clear = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; din = '0;
    clear8 = 1'b0; wr_valid8 = 1'b0; rd_ready8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_waddr", 32'(buf_waddr), 0);
    chk("rst_raddr", 32'(buf_raddr), 0);
    chk("rst_wen", 32'(buf_wen), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst8_count", 32'(count8), 0);

    // Directed table: outputs are checked before each edge.
    foreach (tbl[i]) begin
      clear = tbl[i].clr; wr_valid = tbl[i].wv; rd_ready = tbl[i].rr; din = tbl[i].din;
      #1;
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].c));
      chk($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].c == 6));
      chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].c == 0));
      chk($sformatf("tbl%0d_waddr", i), 32'(buf_waddr), 32'(tbl[i].wa));
      chk($sformatf("tbl%0d_raddr", i), 32'(buf_raddr), 32'(tbl[i].ra));
      chk($sformatf("tbl%0d_wr_ready", i), 32'(wr_ready), 32'(tbl[i].wrdy));
      chk($sformatf("tbl%0d_rd_valid", i), 32'(rd_valid), 32'(tbl[i].rv));
      chk($sformatf("tbl%0d_wen", i), 32'(buf_wen), 32'(tbl[i].wen));
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].er));
      if (tbl[i].rv) chk($sformatf("tbl%0d_dout", i), 32'(dout_win()), 32'(tbl[i].dout));
      @(posedge clk);
      #1;
    end
    clear = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;

    // Random phase against a queue model of stored words.
    word_q.delete();
    wr_words = 0; rd_words = 0; err_m = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int cnt;
      bit m_wrdy, m_rv, m_wen;
      clear    = ($urandom_range(0, 39) == 0);
      wr_valid = $urandom_range(0, 1);
      rd_ready = $urandom_range(0, 1);
      din      = 16'($urandom);
      #1;
      cnt    = word_q.size();
      m_wrdy = (6 - cnt) >= 2;
      m_rv   = cnt >= 3;
      m_wen  = wr_valid && m_wrdy;
      chk("rnd_count", 32'(count), 32'(cnt));
      chk("rnd_waddr", 32'(buf_waddr), 32'(wr_words % 6));
      chk("rnd_raddr", 32'(buf_raddr), 32'(rd_words % 6));
      chk("rnd_wr_ready", 32'(wr_ready), 32'(m_wrdy));
      chk("rnd_rd_valid", 32'(rd_valid), 32'(m_rv));
      chk("rnd_full_empty", 32'({full, empty}), 32'({cnt == 6, cnt == 0}));
      chk("rnd_wen", 32'(buf_wen), 32'(m_wen));
      chk("rnd_err", 32'(err), 32'(ERR_ON && err_m));
      if (m_rv) chk("rnd_dout", 32'(dout_win()), 32'({word_q[2], word_q[1], word_q[0]}));
      if (clear) begin
        word_q.delete();
        wr_words = 0; rd_words = 0; err_m = 1'b0;
      end else begin
        if ((wr_valid && !m_wrdy) || (rd_ready && !m_rv)) err_m = 1'b1;
        if (rd_ready && m_rv) begin
          void'(word_q.pop_front());
          rd_words++;
        end
        if (m_wen) begin
          word_q.push_back(din[7:0]);
          word_q.push_back(din[15:8]);
          wr_words += 2;
        end
      end
      @(posedge clk);
      #1;
    end
    clear = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0;
    @(posedge clk);
    #1;
    clear = 1'b0;
    #1;
    chk("clr_count", 32'(count), 0);
    chk("clr_ptrs", 32'({buf_waddr, buf_raddr}), 0);
    chk("clr_err", 32'(err), 0);

    // Power-of-two depth: a 20-write streaming run must wrap the pointers modulo 8.
    begin
      int w8, r8, c8;
      w8 = 0; r8 = 0; c8 = 0;
      for (int k = 0; k < 20; k++) begin
        wr_valid8 = 1'b1;
        rd_ready8 = (k % 3) != 2;
        #1;
        chk("d8_waddr", 32'(buf_waddr8), 32'(w8 % 8));
        chk("d8_raddr", 32'(buf_raddr8), 32'(r8 % 8));
        chk("d8_count", 32'(count8), 32'(c8));
        chk("d8_wr_ready", 32'(wr_ready8), 32'(c8 < 8));
        if (rd_ready8 && c8 >= 1) begin r8++; c8--; end
        if (c8 + (rd_ready8 && (r8 > 0)) < 9) begin end
        w8++; c8++;
        @(posedge clk);
        #1;
      end
      wr_valid8 = 1'b0; rd_ready8 = 1'b0;
      #1;
      chk("d8_final_waddr", 32'(buf_waddr8), 32'(20 % 8));
      chk("d8_final_raddr", 32'(buf_raddr8), 32'(r8 % 8));
      chk("d8_final_count", 32'(count8), 32'(c8));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
